// File: rtl/dat_xfer_sched.sv
// dat_xfer_sched: SD host data-transfer block scheduler; define SD_DAT_XFER_TIMEOUT_EN to enable the XFER data timeout
module dat_xfer_sched #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd65535
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start_transfer,
  input  logic [15:0] transfer_mode_register,
  input  logic [15:0] block_size_register,
  input  logic [15:0] block_count_register,
  input  logic [15:0] block_gap_control_register,
  input  logic        tx_buf_empty,
  input  logic        rx_buf_full,
  input  logic        dat_block_done,
  input  logic        dat_crc_error,
  output logic        dat_start,
  output logic        dat_direction,
  output logic [11:0] dat_block_size,
  output logic [15:0] blocks_remaining,
  output logic        xfer_active,
  output logic        transfer_complete,
  output logic        block_gap_event,
  output logic        data_crc_err,
  output logic        data_timeout_err
);
  typedef enum logic [2:0] {IDLE, WAIT_BUF, START, XFER, GAP, DONE} state_t;
  state_t state;
  logic infinite;
  logic stop_q;
  logic [15:0] next_rem;
  logic unused_bits;
  assign unused_bits = ^{transfer_mode_register[15:6], transfer_mode_register[3:2], transfer_mode_register[0],
                         block_size_register[15:12], block_gap_control_register[15:2]};
  assign next_rem = (infinite || blocks_remaining == 16'd0) ? blocks_remaining : blocks_remaining - 16'd1;
`ifdef SD_DAT_XFER_TIMEOUT_EN
  logic [23:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign data_timeout_err = 1'b0;
`endif
  // stop_q lags the register one cycle so a change coinciding with dat_block_done applies to the next block
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      infinite <= 1'b0;
      stop_q <= 1'b0;
      dat_start <= 1'b0;
      dat_direction <= 1'b0;
      dat_block_size <= 12'd0;
      blocks_remaining <= 16'd0;
      xfer_active <= 1'b0;
      transfer_complete <= 1'b0;
      block_gap_event <= 1'b0;
      data_crc_err <= 1'b0;
`ifdef SD_DAT_XFER_TIMEOUT_EN
      data_timeout_err <= 1'b0;
      tmo_cnt <= 24'd0;
`endif
    end else begin
      dat_start <= 1'b0;
      transfer_complete <= 1'b0;
      block_gap_event <= 1'b0;
      stop_q <= block_gap_control_register[0];
      case (state)
        IDLE: if (start_transfer) begin
          dat_direction <= transfer_mode_register[4];
          dat_block_size <= block_size_register[11:0];
          infinite <= transfer_mode_register[5] && !transfer_mode_register[1];
          blocks_remaining <= !transfer_mode_register[5] ? 16'd1 :
                              transfer_mode_register[1] ? block_count_register : 16'hFFFF;
          data_crc_err <= 1'b0;
`ifdef SD_DAT_XFER_TIMEOUT_EN
          data_timeout_err <= 1'b0;
`endif
          if (transfer_mode_register[5] && transfer_mode_register[1] && block_count_register == 16'd0) begin
            state <= DONE;
            transfer_complete <= 1'b1;
          end else begin
            state <= WAIT_BUF;
            xfer_active <= 1'b1;
          end
        end
        WAIT_BUF: if (dat_direction ? !rx_buf_full : !tx_buf_empty) begin
          state <= START;
          dat_start <= 1'b1;
`ifdef SD_DAT_XFER_TIMEOUT_EN
          tmo_cnt <= 24'd0;
`endif
        end
        START: state <= XFER;
        XFER: if (dat_block_done) begin
          blocks_remaining <= next_rem;
          if (dat_crc_error || next_rem == 16'd0) begin
            data_crc_err <= data_crc_err | dat_crc_error;
            state <= DONE;
            transfer_complete <= 1'b1;
            xfer_active <= 1'b0;
          end else if (stop_q) begin
            state <= GAP;
            block_gap_event <= 1'b1;
          end else begin
            state <= WAIT_BUF;
          end
        end
`ifdef SD_DAT_XFER_TIMEOUT_EN
        else if (tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
          data_timeout_err <= 1'b1;
          state <= DONE;
          transfer_complete <= 1'b1;
          xfer_active <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 24'd1;
        end
`endif
        GAP: if (block_gap_control_register[1]) state <= WAIT_BUF;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dat_xfer_sched.md
DAT_XFER_SCHED -- requirements
Module: dat_xfer_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd65535, meaning CLK cycles allowed in XFER before a data timeout.
REQ-002 SHALL have port CLK, input, 1, host clock; all logic is on the rising edge.
REQ-003 SHALL have port RESET, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port start_transfer, input, 1, one-cycle pulse that requests a new data transfer.
REQ-005 SHALL have port transfer_mode_register, input, 16, where bit1 = block count enable, bit4 = direction (1 = card-to-host read) and bit5 = multi-block.
REQ-006 SHALL have port block_size_register, input, 16, where bits [11:0] give the block length in bytes.
REQ-007 SHALL have port block_count_register, input, 16, number of blocks to transfer.
REQ-008 SHALL have port block_gap_control_register, input, 16, where bit0 = stop at block gap and bit1 = continue request.
REQ-009 SHALL have port tx_buf_empty, input, 1, TX FIFO empty flag.
REQ-010 SHALL have port rx_buf_full, input, 1, RX FIFO full flag.
REQ-011 SHALL have port dat_block_done, input, 1, DAT engine pulse at the end of a block.
REQ-012 SHALL have port dat_crc_error, input, 1, DAT engine CRC-fail pulse, qualified by dat_block_done.
REQ-013 SHALL have port dat_start, output, 1, one-cycle pulse that starts one block in the DAT engine.
REQ-014 SHALL have port dat_direction, output, 1, latched direction bit.
REQ-015 SHALL have port dat_block_size, output, 12, latched block length.
REQ-016 SHALL have port blocks_remaining, output, 16, live count of blocks still to transfer.
REQ-017 SHALL have port xfer_active, output, 1, high from leaving IDLE until entering DONE.
REQ-018 SHALL have port transfer_complete, output, 1, one-cycle pulse that maps to NISR bit1.
REQ-019 SHALL have port block_gap_event, output, 1, one-cycle pulse that maps to NISR bit2.
REQ-020 SHALL have port data_crc_err, output, 1, sticky flag that maps to EISR bit5.
REQ-021 SHALL have port data_timeout_err, output, 1, sticky flag that maps to EISR bit4.

Function
REQ-022 SHALL implement the states IDLE, WAIT_BUF, START, XFER, GAP and DONE, one-hot or binary.
REQ-023 SHALL, in IDLE, on start_transfer, latch direction and block size and load blocks_remaining, then go to WAIT_BUF.
REQ-024 SHALL load blocks_remaining as follows: multi = 0 gives 1; multi = 1 with count enable = 1 gives block_count_register; multi = 1 with count enable = 0 gives 16'hFFFF, treated as infinite and never decremented.
REQ-025 SHALL, when the loaded count is 0 with count enable = 1, go straight to DONE with no dat_start.
REQ-026 SHALL, in WAIT_BUF, go to START when direction = write and tx_buf_empty = 0, or when direction = read and rx_buf_full = 0; it otherwise stays in WAIT_BUF indefinitely.
REQ-027 SHALL, in START, assert dat_start for exactly one cycle, then go to XFER.
REQ-028 SHALL, in XFER, on dat_block_done, decrement blocks_remaining by 1 unless infinite; the decrement SHALL saturate at 0 and never wrap.
REQ-029 SHALL, on dat_block_done with dat_crc_error = 1, set data_crc_err and go to DONE.
REQ-030 SHALL, after a good block, go to DONE when blocks_remaining becomes 0.
REQ-031 SHALL, after a good block with blocks remaining and stop-at-gap = 1, pulse block_gap_event and go to GAP.
REQ-032 SHALL otherwise go from a good block to WAIT_BUF.
REQ-033 SHALL, in GAP, go to WAIT_BUF on continue request = 1.
REQ-034 SHALL, in GAP, ignore start_transfer.
REQ-035 SHALL, in DONE, pulse transfer_complete for exactly one cycle, then go to IDLE; the error path also pulses transfer_complete.
REQ-036 SHALL ignore start_transfer in every state other than IDLE.
REQ-037 SHALL give dat_block_done priority over any simultaneous block_gap_control change, which then takes effect on the next block.
REQ-038 SHALL clear the sticky error flags only on the next accepted start_transfer or on RESET.
REQ-039 SHALL produce transfer_complete 1 cycle after the final dat_block_done, via DONE.

Reset
REQ-040 SHALL, while RESET = 1 at a CLK edge, enter IDLE.
REQ-041 SHALL, while RESET = 1 at a CLK edge, drive all outputs to 0: dat_start, dat_direction, dat_block_size = 12'd0, blocks_remaining = 16'd0, xfer_active, transfer_complete, block_gap_event and both error flags.
REQ-042 SHALL, on RESET asserted mid-transfer, abort with no transfer_complete pulse.

Configuration
REQ-043 SHALL, with SD_DAT_XFER_TIMEOUT_EN defined, run a 24-bit counter in XFER that clears on each dat_start.
REQ-044 SHALL, with SD_DAT_XFER_TIMEOUT_EN defined, on the counter reaching TIMEOUT_CYCLES, set data_timeout_err and go to DONE.
REQ-045 SHALL, with SD_DAT_XFER_TIMEOUT_EN undefined, have no counter, tie data_timeout_err to 0, and wait in XFER indefinitely.

Verification
REQ-046 SHALL cover: write, single block, size 512, tx_buf_empty = 0 -> dat_start 2 cycles after start_transfer, dat_block_size = 12'd512, transfer_complete 1 cycle after dat_block_done.
REQ-047 SHALL cover: read, multi-block, count = 3, count enable = 1 -> exactly 3 dat_start pulses, blocks_remaining 3→2→1→0, then one transfer_complete.
REQ-048 SHALL cover: count = 4 with stop-at-gap set after block 1, continue asserted 10 cycles later -> block_gap_event after block 1, no dat_start during GAP, then 3 more blocks.
REQ-049 SHALL cover: dat_crc_error on block 2 of 5 -> data_crc_err = 1, transfer_complete pulse, blocks_remaining = 3.
REQ-050 SHALL cover: count enable = 1 with count = 0 -> transfer_complete within 2 cycles and no dat_start.
REQ-051 SHALL cover: with SD_DAT_XFER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 100, no dat_block_done -> data_timeout_err set at cycle 100 of XFER; with RESET mid-XFER, all outputs 0 on the next cycle.
